// File: rtl/cell_state_seq.sv
// rtl/cell_state_seq.sv - LSTM cell-state update sequencer across NUM_UNITS hidden units
// Holds c[], forms the forget-path product and hands each unit to the external MAQ quantizer.
module cell_state_seq #(
  parameter int unsigned NUM_UNITS        = 32,
  parameter int unsigned IDX_W            = 5,
  parameter logic [7:0]  OUT_ZERO_SIGMOID = 8'd0,
  parameter logic [7:0]  ZERO_STATE       = 8'd128,
  parameter logic [4:0]  MAQ_CODE         = 5'd3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    clear_state,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              f_q,
  input  logic [7:0]              i_q,
  input  logic [7:0]              g_q,
  output logic [4:0]              comb_ctrl,
  output logic [16:0]             temp_regA,
  output logic [7:0]              temp_regB,
  output logic [7:0]              temp_regC,
  input  logic [7:0]              S_sat_MAQ,
  output logic                    c_out_valid,
  input  logic                    c_out_ready,
  output logic [7:0]              c_out,
  output logic [IDX_W-1:0]        c_out_idx,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_EVAL,
    S_OUT,
    S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       c_q [NUM_UNITS];
  logic [16:0]      temp_a_q;
  logic [7:0]       temp_b_q;
  logic [7:0]       temp_c_q;
  logic [7:0]       c_out_q;
  logic [IDX_W-1:0] c_out_idx_q;

  logic             c_we;
  logic [7:0]       c_wdata;
  logic             load_temp;
  logic             load_out;

  // Both operands are offset in 9-bit signed space so f=255 / c=0 stay representable.
  logic signed [8:0]  f_off;
  logic signed [8:0]  c_off;
  logic signed [17:0] prod;

  assign f_off = $signed({1'b0, f_q}) - $signed({1'b0, OUT_ZERO_SIGMOID});
  assign c_off = $signed({1'b0, c_q[idx_q]}) - $signed({1'b0, ZERO_STATE});
  assign prod  = f_off * c_off;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    c_we        = 1'b0;
    c_wdata     = S_sat_MAQ;
    load_temp   = 1'b0;
    load_out    = 1'b0;
    in_ready    = 1'b0;
    comb_ctrl   = 5'd0;
    c_out_valid = 1'b0;
    done        = 1'b0;
    busy        = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (clear_state) begin
          state_d = S_CLR;
          idx_d   = '0;
        end else if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_CLR: begin
        c_we    = 1'b1;
        c_wdata = ZERO_STATE;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_temp = 1'b1;
          state_d   = S_EVAL;
        end
      end
      S_EVAL: begin
        // The quantizer is combinational: its result is valid within this cycle.
        comb_ctrl = MAQ_CODE;
        c_we      = 1'b1;
        load_out  = 1'b1;
        state_d   = S_OUT;
      end
      S_OUT: begin
        c_out_valid = 1'b1;
        if (c_out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      temp_a_q    <= '0;
      temp_b_q    <= '0;
      temp_c_q    <= '0;
      c_out_q     <= '0;
      c_out_idx_q <= '0;
      for (int k = 0; k < int'(NUM_UNITS); k++) begin
        c_q[k] <= ZERO_STATE;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (c_we) begin
        c_q[idx_q] <= c_wdata;
      end
      if (load_temp) begin
        temp_a_q <= prod[16:0];
        temp_b_q <= i_q;
        temp_c_q <= g_q;
      end
      if (load_out) begin
        c_out_q     <= S_sat_MAQ;
        c_out_idx_q <= idx_q;
      end
    end
  end

  assign temp_regA = temp_a_q;
  assign temp_regB = temp_b_q;
  assign temp_regC = temp_c_q;
  assign c_out     = c_out_q;
  assign c_out_idx = c_out_idx_q;

endmodule

// File: tb/tb_cell_state_seq.sv
// tb/tb_cell_state_seq.sv - self-checking bench for cell_state_seq
// Quantizer stub: c' = sat(128 + trunc(A/256) + trunc(i*(g-128)/256)), or 0 when force_zero.
module tb_cell_state_seq;
  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        clear_state;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  f_q;
  logic [7:0]  i_q;
  logic [7:0]  g_q;
  logic [4:0]  comb_ctrl;
  logic [16:0] temp_regA;
  logic [7:0]  temp_regB;
  logic [7:0]  temp_regC;
  logic [7:0]  S_sat_MAQ;
  logic        c_out_valid;
  logic        c_out_ready;
  logic [7:0]  c_out;
  logic [4:0]  c_out_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int mc [N];
  int tf [N];
  int ti [N];
  int tg [N];
  bit force_zero = 1'b0;

  always #5 clk = ~clk;

  cell_state_seq dut (
    .clk(clk), .rstn(rstn), .start(start), .clear_state(clear_state),
    .in_valid(in_valid), .in_ready(in_ready), .f_q(f_q), .i_q(i_q), .g_q(g_q),
    .comb_ctrl(comb_ctrl), .temp_regA(temp_regA), .temp_regB(temp_regB),
    .temp_regC(temp_regC), .S_sat_MAQ(S_sat_MAQ), .c_out_valid(c_out_valid),
    .c_out_ready(c_out_ready), .c_out(c_out), .c_out_idx(c_out_idx),
    .busy(busy), .done(done)
  );

  function automatic int quant(int a, int i, int g);
    int s;
    s = 128 + a / 256 + (i * (g - 128)) / 256;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  assign S_sat_MAQ = force_zero ? 8'd0
                   : 8'(quant($signed(temp_regA), int'(temp_regB), int'(temp_regC)));

  task automatic model_clear();
    for (int u = 0; u < N; u++) mc[u] = 128;
  endtask

  task automatic rand_data();
    for (int u = 0; u < N; u++) begin
      tf[u] = $urandom_range(255, 0);
      ti[u] = $urandom_range(255, 0);
      tg[u] = $urandom_range(255, 0);
    end
  endtask

  task automatic run_ts(input int max_gap, input int stall_lo, input int stall_hi,
                        input int abort_at, input bit chk_lat);
    int cyc;
    int gap;
    int k;
    int ea;
    int ec;
    logic [16:0] ea17;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    for (int u = 0; u < N; u++) begin
      if (u == abort_at) begin
        rstn = 1'b0;
        return;
      end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL fetch_state unit %0d in_ready=%b busy=%b want 1 1", u, in_ready, busy);
      end
      gap = $urandom_range(max_gap, 0);
      in_valid = 1'b0;
      repeat (gap) begin
        @(negedge clk);
        cyc++;
      end
      f_q = 8'(tf[u]);
      i_q = 8'(ti[u]);
      g_q = 8'(tg[u]);
      in_valid = 1'b1;
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      f_q = 8'($urandom);
      i_q = 8'($urandom);
      g_q = 8'($urandom);
      ea = tf[u] * (mc[u] - 128);
      ea17 = ea[16:0];
      ec = force_zero ? 0 : quant(ea, ti[u], tg[u]);
      mc[u] = ec;
      checks++;
      if (comb_ctrl !== 5'd3 || in_ready !== 1'b0 || c_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL eval_ctrl unit %0d comb_ctrl=%0d in_ready=%b c_out_valid=%b want 3 0 0",
                 u, comb_ctrl, in_ready, c_out_valid);
      end
      checks++;
      if (temp_regA !== ea17) begin
        errors++;
        $display("FAIL temp_regA unit %0d got %h want %h", u, temp_regA, ea17);
      end
      checks++;
      if (temp_regB !== 8'(ti[u]) || temp_regC !== 8'(tg[u])) begin
        errors++;
        $display("FAIL temp_regBC unit %0d got %0d %0d want %0d %0d",
                 u, temp_regB, temp_regC, ti[u], tg[u]);
      end
      c_out_ready = 1'b0;
      @(negedge clk);
      cyc++;
      checks++;
      if (c_out_valid !== 1'b1 || comb_ctrl !== 5'd0 || c_out !== 8'(ec) || c_out_idx !== 5'(u)) begin
        errors++;
        $display("FAIL c_out unit %0d valid=%b ctrl=%0d c_out=%0d idx=%0d want 1 0 %0d %0d",
                 u, c_out_valid, comb_ctrl, c_out, c_out_idx, ec, u);
      end
      k = $urandom_range(stall_hi, stall_lo);
      repeat (k) begin
        start = 1'($urandom);
        clear_state = 1'($urandom);
        @(negedge clk);
        cyc++;
        start = 1'b0;
        clear_state = 1'b0;
        checks++;
        if (c_out_valid !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 ||
            c_out !== 8'(ec) || c_out_idx !== 5'(u)) begin
          errors++;
          $display("FAIL stall_hold unit %0d valid=%b in_ready=%b done=%b c_out=%0d idx=%0d want 1 0 0 %0d %0d",
                   u, c_out_valid, in_ready, done, c_out, c_out_idx, ec, u);
        end
      end
      c_out_ready = 1'b1;
      @(negedge clk);
      cyc++;
      c_out_ready = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse done=%b busy=%b want 1 1", done, busy);
    end
    if (chk_lat) begin
      checks++;
      if (cyc != 3 * N + 1) begin
        errors++;
        $display("FAIL latency got %0d want %0d", cyc, 3 * N + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({in_ready, c_out_valid, done, busy, comb_ctrl, temp_regA, temp_regB,
         temp_regC, c_out, c_out_idx} !== '0) begin
      errors++;
      $display("FAIL %s in_ready=%b valid=%b done=%b busy=%b ctrl=%0d A=%h B=%0d C=%0d c_out=%0d idx=%0d want all 0",
               tag, in_ready, c_out_valid, done, busy, comb_ctrl, temp_regA, temp_regB,
               temp_regC, c_out, c_out_idx);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    start = 1'b0;
    clear_state = 1'b0;
    in_valid = 1'b0;
    c_out_ready = 1'b0;
    f_q = '0;
    i_q = '0;
    g_q = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_outputs");
    rstn = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset_idle");
    model_clear();
  endtask

  task automatic test_directed();
    rand_data();
    tf[0] = 255; ti[0] = 255; tg[0] = 255;
    run_ts(0, 0, 0, -1, 1'b1);
    rand_data();
    tf[0] = 128; ti[0] = 0; tg[0] = 128;
    run_ts(0, 0, 0, -1, 1'b1);
    force_zero = 1'b1;
    rand_data();
    run_ts(0, 0, 0, -1, 1'b1);
    force_zero = 1'b0;
    rand_data();
    tf[0] = 255; ti[0] = 0; tg[0] = 128;
    run_ts(0, 0, 0, -1, 1'b1);
  endtask

  task automatic test_stall();
    rand_data();
    run_ts(0, 5, 5, -1, 1'b0);
    rand_data();
    run_ts(2, 0, 3, -1, 1'b0);
  endtask

  task automatic test_clear();
    clear_state = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
    start = 1'b0;
    for (int c = 1; c <= N; c++) begin
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || comb_ctrl !== 5'd0) begin
        errors++;
        $display("FAIL clr_busy cycle %0d busy=%b in_ready=%b ctrl=%0d want 1 0 0",
                 c, busy, in_ready, comb_ctrl);
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_end busy=%b want 0", busy);
    end
    model_clear();
    rand_data();
    run_ts(0, 0, 0, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    rand_data();
    run_ts(0, 0, 1, 10, 1'b0);
    #1;
    check_idle_outputs("mid_reset_outputs");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset_idle");
    model_clear();
    rand_data();
    run_ts(0, 0, 0, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    rand_data();
    run_ts(0, 0, 0, -1, 1'b1);
    rand_data();
    run_ts(1, 0, 2, -1, 1'b0);
    rand_data();
    run_ts(0, 0, 0, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cell_state_seq.md
Name:
cell_state_seq

Overview:
- Sequencer for the LSTM cell-state update across NUM_UNITS hidden units in one timestep.
- Accepts quantized gate activations per unit (forget f, input i, candidate g) over a valid/ready stream.
- Holds the 8-bit quantized cell state c[NUM_UNITS] internally and forms the forget-path product (f−zf)·(c−zc).
- Drives the downstream combinational cell-state MAQ quantizer, then writes the returned saturated c_t back and streams it to the h_t stage.

Parameters:
- NUM_UNITS, 32, hidden units per timestep.
- IDX_W, 5, index width; must satisfy 2^IDX_W ≥ NUM_UNITS.
- OUT_ZERO_SIGMOID, 8'd0, zero point of the f quantization.
- ZERO_STATE, 8'd128, zero point of the cell state; also the reset/clear value of c.
- MAQ_CODE, 5'd3, comb_ctrl code that selects the MAQ operation.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a timestep at unit 0
- clear_state  in  1  pulse: set all c entries to ZERO_STATE
- in_valid  in  1  gate triple valid
- in_ready  out  1  gate triple accepted when in_valid && in_ready
- f_q  in  8  forget-gate sigmoid output
- i_q  in  8  input-gate sigmoid output
- g_q  in  8  candidate tanh output
- comb_ctrl  out  5  quantizer operation select
- temp_regA  out  17  signed (f_q−OUT_ZERO_SIGMOID)·(c−ZERO_STATE)
- temp_regB  out  8  registered i_q
- temp_regC  out  8  registered g_q
- S_sat_MAQ  in  8  saturated new cell state from the quantizer
- c_out_valid  out  1  new c_t available
- c_out_ready  in  1  downstream accepts c_out
- c_out  out  8  new c_t
- c_out_idx  out  IDX_W  unit index of c_out
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last unit is accepted

Behaviour:
- Reset values (async, rstn low): state=IDLE, idx=0, every c entry=ZERO_STATE. All outputs 0 except in_ready=0. Reset mid-timestep aborts with no partial write-back.
- FSM states: IDLE, CLR, FETCH, EVAL, OUT, DONE.
- IDLE:
  - clear_state → CLR; clear_state has priority over start in the same cycle (start dropped).
  - start → FETCH, idx=0.
  - start/clear_state are ignored when not in IDLE.
- CLR: writes ZERO_STATE to c[idx], one entry per cycle, idx 0..NUM_UNITS−1 (NUM_UNITS cycles). Then idx=0 → IDLE.
- FETCH: in_ready=1. On handshake, register in the same edge:
  - temp_regB=i_q, temp_regC=g_q.
  - temp_regA = signed({1'b0,f_q}−OUT_ZERO_SIGMOID) × signed({1'b0,c[idx]}−ZERO_STATE). Range −32640..32385; 17-bit two's complement.
  - → EVAL.
- EVAL: comb_ctrl=MAQ_CODE for exactly this one cycle (0 in every other state). At the clock edge, capture c[idx]=S_sat_MAQ, c_out=S_sat_MAQ, c_out_idx=idx → OUT.
- OUT: c_out_valid=1. c_out and c_out_idx are held stable until c_out_ready.
  - On handshake: if idx==NUM_UNITS−1 → DONE; else idx+1 → FETCH.
- DONE: done=1 for one cycle, idx=0 → IDLE.
- temp_regA/B/C hold their last values outside FETCH updates.
- Throughput: 3 cycles/unit minimum (FETCH, EVAL, OUT with in_valid and c_out_ready both high). Start-to-done latency = 3·NUM_UNITS+1 cycles.
- c persists across timesteps. Only reset or clear_state reinitialize it.
- Index wrap: idx never exceeds NUM_UNITS−1. For non-power-of-2 NUM_UNITS, unused entries are never written.

Test Plan:
- Reset, then start. Unit 0 with f=255, i=255, g=255 (c=128) → temp_regA=0, comb_ctrl=3 for one cycle; with the team's MAQ quantizer at defaults, c_out=254, c_out_idx=0.
- Second timestep on unit 0 with f=128, i=0, g=128 → temp_regA=16128 (0x03F00), c_out=191.
- Drive c[0] to 0 (f=0, i=0, g=0 gives 128+0; instead use the quantizer stub returning 0). Then f=255 → temp_regA=−32640 (17'h18080), real quantizer gives c_out=1.
- Hold c_out_ready=0 for 5 cycles in OUT → c_out_valid stays 1, c_out/c_out_idx stable, in_ready=0, no idx advance.
- Full NUM_UNITS=32 run with in_valid and c_out_ready always high → done pulses exactly 97 cycles after start; busy falls the next cycle.
- Assert clear_state and start together in IDLE → CLR for 32 cycles, start ignored, all c=128. Also assert rstn low mid-run at unit 10 → IDLE, all c=128, outputs 0.
